tlb_unit: RTL and testbench
===========================

# tlb_unit

Fully associative instruction/data address-translation buffer. It sits beside the fetch or memory stage and translates virtual addresses to physical addresses. It is the responder side of the pipeline's TLB protocol: it raises `TLB_MISS` toward the control unit, holds it until software executes `tlbwrite`, and consumes the resulting `TLB_WRITE` strobe to refill an entry. One instance serves the instruction side and one serves the data side.

## Interface
Parameters:
- `ENTRIES`, default 8: number of TLB entries; must be a power of two, at least 2.
- `PAGE_BITS`, default 12: page offset width. VPN and PPN widths are 32-`PAGE_BITS` (20 by default).

Ports:
- `clk`  in  1  clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  lookup request this cycle.
- `vaddr`  in  32  virtual address to translate.
- `supervisor`  in  1  translation bypass: `paddr` = `vaddr`, never misses.
- `TLB_WRITE`  in  1  refill strobe from the `tlbwrite` instruction; one cycle per write.
- `write_vpn`  in  32-`PAGE_BITS`  VPN to install.
- `write_ppn`  in  32-`PAGE_BITS`  PPN to install.
- `flush`  in  1  invalidate all entries.
- `resp_valid`  out  1  registered: translation valid this cycle.
- `paddr`  out  32  registered physical address, equal to {PPN, `vaddr[PAGE_BITS-1:0]`}.
- `TLB_MISS`  out  1  registered miss indication to the control unit.
- `miss_vaddr`  out  32  faulting virtual address, held while `TLB_MISS`=1.

## Operation
- Storage: per entry, a valid bit, a VPN and a PPN. Lookup compares the VPN of `vaddr` against all valid entries in parallel. Writes guarantee there are never duplicate VPNs.
- FSM has two states:
  - IDLE to MISS: `req_valid`=1, `supervisor`=0, no hit, and no forwarding hit.
  - MISS to IDLE: `TLB_WRITE`=1. The entry is written at that edge.
  - Nothing else leaves MISS, including `req_valid`, `flush` and `supervisor`.
- IDLE lookup:
  - Hit: `resp_valid`=1, `paddr` translated, `TLB_MISS`=0.
  - Miss: `resp_valid`=0, `TLB_MISS`=1, `miss_vaddr`=`vaddr`.
  - Bypass (`supervisor`=1): `resp_valid`=1, `paddr`=`vaddr`.
  - `req_valid`=0: `resp_valid`=0.
- MISS: `TLB_MISS`=1, `resp_valid`=0. Requests are ignored and `miss_vaddr` is frozen.
- Write victim selection, in priority order:
  1. The entry whose VPN already equals `write_vpn` (overwrite in place).
  2. The lowest-index invalid entry.
  3. The entry at the round-robin pointer `rr_ptr`.
- `rr_ptr` width is log2(`ENTRIES`) and wraps from `ENTRIES`-1 to 0. It advances only when case 3 is used.
- Writes are accepted in both states, so software can preload entries while in IDLE.
- Forwarding: if an IDLE request and `TLB_WRITE` occur in the same cycle and the VPNs match, the request is reported as a hit using `write_ppn`.
- Flush: clears every valid bit and sets `rr_ptr`=0 at the edge.
  - In IDLE, a lookup in the same cycle sees the pre-flush contents.
  - In MISS, the state is unchanged.
  - Flush and `TLB_WRITE` in the same cycle: flush applies first, then the write. The written entry ends up valid, and it is entry 0.

## Timing
- Lookup latency is 1 cycle: request at edge N, response outputs valid after edge N+1.
- `TLB_MISS` rises one cycle after the missing request. It falls one cycle after the `TLB_WRITE` that is sampled in MISS.
- A retried lookup of the refilled VPN issued on the cycle after refill hits.
- Reset (synchronous, overrides everything including a mid-miss state) produces:
  - state IDLE;
  - all valid bits 0;
  - `rr_ptr`=0;
  - `resp_valid`=0, `TLB_MISS`=0;
  - `paddr`=0, `miss_vaddr`=0.
- Throughput: one lookup per cycle in IDLE.

## Test plan
- Reset, then `TLB_WRITE` vpn 0x00010 / ppn 0x00ABC, then lookup `vaddr` 0x00010123 -> next cycle `resp_valid`=1, `paddr`=0x00ABC123, `TLB_MISS`=0.
- Lookup 0x00020456 with the TLB empty -> `TLB_MISS`=1, `miss_vaddr`=0x00020456.
  - Requests during MISS -> `resp_valid` stays 0.
  - Then write vpn 0x00020 / ppn 0x00777 -> `TLB_MISS`=0 the next cycle; retry gives `paddr`=0x00777456.
- Fill all 8 entries (VPNs 1–8), then write VPNs 9 and 10 -> entries 0 and 1 are replaced. VPN 1 and VPN 2 lookups miss; VPN 3 hits.
- Write VPN 5 twice with PPNs 0x1 then 0x2 -> lookup returns PPN 0x2; no other entry is displaced.
- Same-cycle request and write for VPN 0x00030 / PPN 0x00123 -> hit, `paddr`={0x00123, offset}, no miss.
- Assert `reset` while in MISS -> next cycle `TLB_MISS`=0 and all entries miss.
- Assert `flush` with `supervisor`=1 -> `paddr`=`vaddr` with no miss; after clearing `supervisor`, all lookups miss.

Source files
------------

// File: rtl/tlb_unit_if.sv
// tlb_unit_if: groups the lookup request/response, refill and flush
// signals exchanged between the pipeline and a tlb_unit instance.
//   master : pipeline/control side (drives requests, refills, flush)
//   slave  : TLB side (drives responses and the miss indication)
// Signals:
//   req_valid, vaddr, supervisor     lookup request and translation bypass
//   TLB_WRITE, write_vpn, write_ppn  refill strobe and the entry to install
//   flush                            invalidate every entry
//   resp_valid, paddr                registered translation result
//   TLB_MISS, miss_vaddr             registered miss flag and faulting address
interface tlb_unit_if #(
  parameter int PAGE_BITS = 12
);
  localparam int PN_W = 32 - PAGE_BITS;

  logic            req_valid;
  logic [31:0]     vaddr;
  logic            supervisor;
  logic            TLB_WRITE;
  logic [PN_W-1:0] write_vpn;
  logic [PN_W-1:0] write_ppn;
  logic            flush;
  logic            resp_valid;
  logic [31:0]     paddr;
  logic            TLB_MISS;
  logic [31:0]     miss_vaddr;

  modport master (
    output req_valid, vaddr, supervisor, TLB_WRITE, write_vpn, write_ppn, flush,
    input  resp_valid, paddr, TLB_MISS, miss_vaddr
  );

  modport slave (
    input  req_valid, vaddr, supervisor, TLB_WRITE, write_vpn, write_ppn, flush,
    output resp_valid, paddr, TLB_MISS, miss_vaddr
  );
endinterface

// File: rtl/tlb_unit.sv
// tlb_unit: fully associative address-translation buffer. Translates vaddr
// to paddr with one cycle of latency, raises TLB_MISS and holds it until a
// TLB_WRITE refill arrives, and accepts refills/flushes in any state.
// Ports:
//   clk    single clock
//   reset  synchronous active-high reset
//   bus    tlb_unit_if slave modport (request, refill, flush, response, miss)
module tlb_unit #(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12
) (
  input logic       clk,
  input logic       reset,
  tlb_unit_if.slave bus
);
  localparam int PN_W  = 32 - PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, MISS} state_e;

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [PN_W-1:0]    vpn_q [ENTRIES];
  logic [PN_W-1:0]    ppn_q [ENTRIES];
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic               respValid_q, respValid_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        missVaddr_q, missVaddr_d;

  logic [PN_W-1:0]    reqVpn;
  logic               lookupHit;
  logic [PN_W-1:0]    lookupPpn;
  logic               fwdHit;
  logic [ENTRIES-1:0] baseValid;
  logic               matchFound, freeFound, useRr;
  logic [IDX_W-1:0]   matchIdx, freeIdx, victim;

  assign reqVpn = bus.vaddr[31:PAGE_BITS];
  assign fwdHit = bus.TLB_WRITE && (bus.write_vpn == reqVpn);

  // Parallel compare against the stored (pre-write, pre-flush) entries.
  always_comb begin
    lookupHit = 1'b0;
    lookupPpn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == reqVpn)) begin
        lookupHit = 1'b1;
        lookupPpn = ppn_q[i];
      end
    end
  end

  // Victim selection sees the post-flush valid bits so a same-cycle flush
  // and refill lands in entry 0. Scanning downward leaves the lowest free index.
  always_comb begin
    baseValid  = bus.flush ? '0 : valid_q;
    matchFound = 1'b0;
    matchIdx   = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (baseValid[i] && (vpn_q[i] == bus.write_vpn)) begin
        matchFound = 1'b1;
        matchIdx   = IDX_W'(i);
      end
      if (!baseValid[i]) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
    useRr   = !matchFound && !freeFound;
    victim  = matchFound ? matchIdx : (freeFound ? freeIdx : rrPtr_q);
    valid_d = baseValid;
    rrPtr_d = bus.flush ? '0 : rrPtr_q;
    if (bus.TLB_WRITE) begin
      valid_d[victim] = 1'b1;
      if (useRr) begin
        rrPtr_d = rrPtr_q + IDX_W'(1);
      end
    end
  end

  // Next-state and response logic; only a refill strobe leaves MISS.
  always_comb begin
    state_d     = state_q;
    respValid_d = 1'b0;
    paddr_d     = paddr_q;
    missVaddr_d = missVaddr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.supervisor) begin
            respValid_d = 1'b1;
            paddr_d     = bus.vaddr;
          end else if (fwdHit) begin
            respValid_d = 1'b1;
            paddr_d     = {bus.write_ppn, bus.vaddr[PAGE_BITS-1:0]};
          end else if (lookupHit) begin
            respValid_d = 1'b1;
            paddr_d     = {lookupPpn, bus.vaddr[PAGE_BITS-1:0]};
          end else begin
            state_d     = MISS;
            missVaddr_d = bus.vaddr;
          end
        end
      end
      MISS: begin
        if (bus.TLB_WRITE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rrPtr_q     <= '0;
      respValid_q <= 1'b0;
      paddr_q     <= '0;
      missVaddr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rrPtr_q     <= rrPtr_d;
      respValid_q <= respValid_d;
      paddr_q     <= paddr_d;
      missVaddr_q <= missVaddr_d;
    end
  end

  // Tag/data storage needs no reset: nothing is visible until its valid bit is set.
  always_ff @(posedge clk) begin
    if (bus.TLB_WRITE) begin
      vpn_q[victim] <= bus.write_vpn;
      ppn_q[victim] <= bus.write_ppn;
    end
  end

  assign bus.resp_valid = respValid_q;
  assign bus.paddr      = paddr_q;
  assign bus.TLB_MISS   = (state_q == MISS);
  assign bus.miss_vaddr = missVaddr_q;
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: drives tlb_unit through directed scenarios and a randomized
// run, comparing every response against a behavioural TLB model.
module tb_tlb_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;

  tlb_unit_if #(.PAGE_BITS(12)) bus ();

  tlb_unit #(.ENTRIES(8), .PAGE_BITS(12)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a table of (valid, vpn, ppn), a replacement pointer
  // and a "waiting for refill" flag, plus the outputs expected next.
  bit          mValid [8];
  logic [19:0] mVpn [8];
  logic [19:0] mPpn [8];
  int          mRr;
  bit          mMiss;
  bit          expResp;
  logic [31:0] expPaddr;
  logic [31:0] expMissVaddr;

  task automatic modelStep(input bit r, input bit req, input bit sup, input logic [31:0] va,
                           input bit wr, input logic [19:0] wv, input logic [19:0] wp, input bit fl);
    bit nextMiss;
    bit found;
    int slot;
    logic [19:0] p;
    if (r) begin
      foreach (mValid[i]) mValid[i] = 0;
      mRr = 0; mMiss = 0; expResp = 0; expPaddr = 0; expMissVaddr = 0;
      return;
    end
    nextMiss = mMiss;
    expResp = 0;
    if (!mMiss && req) begin
      if (sup) begin
        expResp = 1; expPaddr = va;
      end else begin
        found = 0; p = 0;
        if (wr && wv == va[31:12]) begin found = 1; p = wp; end
        else foreach (mValid[i]) if (mValid[i] && mVpn[i] == va[31:12]) begin found = 1; p = mPpn[i]; end
        if (found) begin expResp = 1; expPaddr = {p, va[11:0]}; end
        else begin nextMiss = 1; expMissVaddr = va; end
      end
    end else if (mMiss && wr) begin
      nextMiss = 0;
    end
    if (fl) begin
      foreach (mValid[i]) mValid[i] = 0;
      mRr = 0;
    end
    if (wr) begin
      slot = -1;
      foreach (mValid[i]) if (mValid[i] && mVpn[i] == wv) slot = i;
      if (slot < 0) foreach (mValid[i]) if (slot < 0 && !mValid[i]) slot = i;
      if (slot < 0) begin slot = mRr; mRr = (mRr + 1) % 8; end
      mValid[slot] = 1; mVpn[slot] = wv; mPpn[slot] = wp;
    end
    mMiss = nextMiss;
  endtask

  // Apply one cycle of inputs, clock it, and advance the model alongside.
  task automatic drive(input bit r, input bit req, input bit sup, input logic [31:0] va,
                       input bit wr, input logic [19:0] wv, input logic [19:0] wp, input bit fl);
    reset = r;
    bus.req_valid = req; bus.supervisor = sup; bus.vaddr = va;
    bus.TLB_WRITE = wr; bus.write_vpn = wv; bus.write_ppn = wp; bus.flush = fl;
    @(posedge clk);
    #1;
    modelStep(r, req, sup, va, wr, wv, wp, fl);
  endtask

  task automatic lookup(input logic [31:0] va);
    drive(0, 1, 0, va, 0, 20'h0, 20'h0, 0);
  endtask

  task automatic refill(input logic [19:0] v, input logic [19:0] p);
    drive(0, 0, 0, 32'h0, 1, v, p, 0);
  endtask

  function automatic logic [65:0] observed();
    return {bus.resp_valid, bus.resp_valid ? bus.paddr : 32'h0,
            bus.TLB_MISS, bus.TLB_MISS ? bus.miss_vaddr : 32'h0};
  endfunction

  function automatic logic [65:0] expected();
    return {expResp, expResp ? expPaddr : 32'h0, mMiss, mMiss ? expMissVaddr : 32'h0};
  endfunction

  task automatic test_reset();
    drive(1, 0, 0, 32'h0, 0, 20'h0, 20'h0, 0);
    nChecks++;
    if ({bus.resp_valid, bus.paddr, bus.TLB_MISS, bus.miss_vaddr} !== 66'h0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {bus.resp_valid, bus.paddr, bus.TLB_MISS, bus.miss_vaddr});
    end
  endtask

  task automatic test_basic_hit();
    refill(20'h00010, 20'h00ABC);
    lookup(32'h00010123);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00ABC123 || bus.TLB_MISS !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL basic_hit: got resp=%b paddr=%h miss=%b required 1/00abc123/0",
               bus.resp_valid, bus.paddr, bus.TLB_MISS);
    end
  endtask

  task automatic test_miss_refill();
    drive(1, 0, 0, 32'h0, 0, 20'h0, 20'h0, 0);
    lookup(32'h00020456);
    nChecks++;
    if (bus.TLB_MISS !== 1'b1 || bus.miss_vaddr !== 32'h00020456 || bus.resp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL miss_raise: got miss=%b vaddr=%h resp=%b required 1/00020456/0",
               bus.TLB_MISS, bus.miss_vaddr, bus.resp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 2, 32'h00050000 + i, 0, 20'h0, 20'h0, i == 1);
      nChecks++;
      if (observed() !== expected()) begin
        nFail++;
        $display("[TB] FAIL miss_hold%0d: got %h required %h", i, observed(), expected());
      end
    end
    refill(20'h00020, 20'h00777);
    nChecks++;
    if (bus.TLB_MISS !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL miss_clear: got %b required 0", bus.TLB_MISS);
    end
    lookup(32'h00020456);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00777456) begin
      nFail++;
      $display("[TB] FAIL miss_retry: got resp=%b paddr=%h required 1/00777456",
               bus.resp_valid, bus.paddr);
    end
  endtask

  task automatic test_replacement();
    drive(1, 0, 0, 32'h0, 0, 20'h0, 20'h0, 0);
    for (int v = 1; v <= 10; v++) refill(20'(v), 20'(v + 32'h100));
    lookup(32'h00003AAA);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00103AAA) begin
      nFail++;
      $display("[TB] FAIL repl_vpn3: got resp=%b paddr=%h required 1/00103aaa", bus.resp_valid, bus.paddr);
    end
    lookup(32'h00001000);
    nChecks++;
    if (bus.TLB_MISS !== 1'b1 || observed() !== expected()) begin
      nFail++;
      $display("[TB] FAIL repl_vpn1: got %h required %h", observed(), expected());
    end
    refill(20'h00055, 20'h00066);
    lookup(32'h00002000);
    nChecks++;
    if (bus.TLB_MISS !== 1'b1 || observed() !== expected()) begin
      nFail++;
      $display("[TB] FAIL repl_vpn2: got %h required %h", observed(), expected());
    end
    refill(20'h00002, 20'h00222);
  endtask

  task automatic test_overwrite();
    logic [19:0] vpns [9];
    vpns = '{20'd5, 20'd5, 20'd1, 20'd2, 20'd3, 20'd4, 20'd6, 20'd7, 20'd8};
    drive(1, 0, 0, 32'h0, 0, 20'h0, 20'h0, 0);
    refill(20'd5, 20'h1);
    refill(20'd5, 20'h2);
    for (int i = 2; i < 9; i++) refill(vpns[i], vpns[i] + 20'h300);
    for (int i = 1; i < 9; i++) begin
      lookup({vpns[i], 12'h5A5});
      nChecks++;
      if (bus.resp_valid !== 1'b1 || observed() !== expected()) begin
        nFail++;
        $display("[TB] FAIL overwrite_vpn%0d: got %h required %h", vpns[i], observed(), expected());
      end
      if (bus.TLB_MISS) refill(20'h000FF, 20'h0);
    end
    lookup(32'h000055A5);
    nChecks++;
    if (bus.paddr !== 32'h000025A5) begin
      nFail++;
      $display("[TB] FAIL overwrite_ppn: got %h required 000025a5", bus.paddr);
    end
  endtask

  task automatic test_forwarding();
    drive(0, 1, 0, 32'h00030ABC, 1, 20'h00030, 20'h00123, 0);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00123ABC || bus.TLB_MISS !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL forward: got resp=%b paddr=%h miss=%b required 1/00123abc/0",
               bus.resp_valid, bus.paddr, bus.TLB_MISS);
    end
  endtask

  task automatic test_reset_in_miss();
    lookup(32'h00099000);
    drive(1, 1, 0, 32'h00099000, 0, 20'h0, 20'h0, 0);
    nChecks++;
    if (bus.TLB_MISS !== 1'b0 || bus.resp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_in_miss: got miss=%b resp=%b required 0/0", bus.TLB_MISS, bus.resp_valid);
    end
    lookup(32'h00030ABC);
    nChecks++;
    if (bus.TLB_MISS !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_clears_entries: got miss=%b required 1", bus.TLB_MISS);
    end
    refill(20'h00030, 20'h00001);
  endtask

  task automatic test_flush_supervisor();
    refill(20'h00040, 20'h00444);
    drive(0, 1, 1, 32'h00040321, 0, 20'h0, 20'h0, 1);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00040321 || bus.TLB_MISS !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL flush_bypass: got resp=%b paddr=%h miss=%b required 1/00040321/0",
               bus.resp_valid, bus.paddr, bus.TLB_MISS);
    end
    lookup(32'h00040321);
    nChecks++;
    if (bus.TLB_MISS !== 1'b1 || bus.resp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL flush_cleared: got miss=%b resp=%b required 1/0", bus.TLB_MISS, bus.resp_valid);
    end
    drive(0, 0, 0, 32'h0, 1, 20'h00060, 20'h00666, 1);
    lookup(32'h00060001);
    nChecks++;
    if (bus.resp_valid !== 1'b1 || bus.paddr !== 32'h00666001) begin
      nFail++;
      $display("[TB] FAIL flush_then_write: got resp=%b paddr=%h required 1/00666001", bus.resp_valid, bus.paddr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            {20'($urandom_range(0, 11)), 12'($urandom)}, $urandom_range(0, 3) == 0,
            20'($urandom_range(0, 11)), 20'($urandom), $urandom_range(0, 29) == 0);
      nChecks++;
      if (observed() !== expected()) begin
        nFail++;
        $display("[TB] FAIL random_cycle%0d: got %h required %h", n, observed(), expected());
      end
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.supervisor = 0; bus.vaddr = 0;
    bus.TLB_WRITE = 0; bus.write_vpn = 0; bus.write_ppn = 0; bus.flush = 0;
    test_reset();
    test_basic_hit();
    test_miss_refill();
    test_replacement();
    test_overwrite();
    test_forwarding();
    test_reset_in_miss();
    test_flush_supervisor();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
